m_stage_data_mem: RTL and testbench

//  M-stage data memory for the 5-stage pipelined MIPS core; consumes the forwarded store data produced by the M-stage write-data mux.

---
 rtl/m_stage_data_mem.sv | 131 +++++++++++++
 tb/tb_m_stage_data_mem.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/m_stage_data_mem.sv
// m_stage_data_mem: M-stage data memory for the 5-stage MIPS pipeline.
// Word array with sw/sh/sb byte-lane writes, combinational lw/lh/lhu/lb/lbu
// reads with sign/zero extension, and load/store address-exception flags.
// Optional write logging is enabled by defining DM_WRITE_LOG_EN.
module m_stage_data_mem #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_M,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic        MemWrite,
  input  logic [1:0]  StoreType,
  input  logic [2:0]  LoadType,
  output logic [31:0] RD,
  output logic        AdEL,
  output logic        AdES
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  // Byte span held in 33 bits so the range check never overflows.
  localparam logic [32:0] SPAN_BYTES = 33'(4) << DEPTH_LOG2;

  typedef enum logic [1:0] {
    ST_SW  = 2'b00,
    ST_SH  = 2'b01,
    ST_SB  = 2'b10,
    ST_RSV = 2'b11
  } store_t;

  typedef enum logic [2:0] {
    LD_LW  = 3'b000,
    LD_LBU = 3'b001,
    LD_LB  = 3'b010,
    LD_LHU = 3'b011,
    LD_LH  = 3'b100
  } load_t;

  logic [31:0]           mem [DEPTH];
  logic [31:0]           off;
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            lane;
  logic                  in_range;
  logic [31:0]           word;
  logic [31:0]           new_word;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [31:0]           rd_ext;
  logic                  wr_en;

  assign off      = Addr - ADDR_BASE;
  assign idx      = off[DEPTH_LOG2+1:2];
  assign lane     = off[1:0];
  assign in_range = {1'b0, off} < SPAN_BYTES;
  assign word     = mem[idx];
  assign wr_en    = MemWrite & ~AdES;

  // Address exception flags: store errors only while writing, load errors only while not.
  always_comb begin
    AdES = 1'b0;
    AdEL = 1'b0;
    if (MemWrite) begin
      unique case (StoreType)
        ST_SW:   AdES = ~in_range | (lane != 2'b00);
        ST_SH:   AdES = ~in_range | lane[0];
        ST_SB:   AdES = ~in_range;
        default: AdES = 1'b1;
      endcase
    end else begin
      case (LoadType)
        LD_LBU, LD_LB: AdEL = ~in_range;
        LD_LHU, LD_LH: AdEL = ~in_range | lane[0];
        default:       AdEL = ~in_range | (lane != 2'b00);
      endcase
    end
  end

  // Merge store data into the addressed word on the selected byte lanes.
  always_comb begin
    new_word = word;
    unique case (StoreType)
      ST_SW: new_word = WD;
      ST_SH: begin
        if (lane[1]) new_word[31:16] = WD[15:0];
        else         new_word[15:0]  = WD[15:0];
      end
      ST_SB:   new_word[{lane, 3'b000} +: 8] = WD[7:0];
      default: new_word = word;
    endcase
  end

  // Select and extend load data; an address error forces zero.
  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    case (LoadType)
      LD_LBU:  rd_ext = {24'b0, byte_sel};
      LD_LB:   rd_ext = {{24{byte_sel[7]}}, byte_sel};
      LD_LHU:  rd_ext = {16'b0, half_sel};
      LD_LH:   rd_ext = {{16{half_sel[15]}}, half_sel};
      default: rd_ext = word;
    endcase
    RD = AdEL ? '0 : rd_ext;
  end

  // Array update: reset clears every word and takes priority over a store.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[idx] <= new_word;
    end
  end

`ifdef DM_WRITE_LOG_EN
  // Trace each committed store with the full merged word.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      $display("%d@%h: *%h <= %h", $time, PC_M, {Addr[31:2], 2'b00}, new_word);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^PC_M;
`endif

endmodule

// File: tb/tb_m_stage_data_mem.sv
// Scoreboard bench for m_stage_data_mem: each directed operation pushes its
// hand-computed response; a monitor on the falling edge pops and compares.
module tb_m_stage_data_mem;

  logic        clk;
  logic        reset;
  logic [31:0] PC_M;
  logic [31:0] Addr;
  logic [31:0] WD;
  logic        MemWrite;
  logic [1:0]  StoreType;
  logic [2:0]  LoadType;
  logic [31:0] RD;
  logic        AdEL;
  logic        AdES;

  typedef struct packed {
    logic        chk_rd;
    logic [31:0] rd;
    logic        adel;
    logic        ades;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  m_stage_data_mem #(.DEPTH_LOG2(10), .ADDR_BASE(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .PC_M(PC_M), .Addr(Addr), .WD(WD),
    .MemWrite(MemWrite), .StoreType(StoreType), .LoadType(LoadType),
    .RD(RD), .AdEL(AdEL), .AdES(AdES)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation for one cycle and queue its expected response.
  task automatic op(input logic rst, input logic we, input logic [1:0] st,
                    input logic [2:0] lt, input logic [31:0] a, input logic [31:0] wd,
                    input logic chk, input logic [31:0] erd, input logic eadel,
                    input logic eades, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; MemWrite = we; StoreType = st; LoadType = lt;
    Addr = a; WD = wd; PC_M = PC_M + 32'd4;
    e.chk_rd = chk; e.rd = erd; e.adel = eadel; e.ades = eades;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic ld(input logic [2:0] lt, input logic [31:0] a, input logic [31:0] erd,
                    input logic eadel, input string nm);
    op(1'b0, 1'b0, 2'b00, lt, a, 32'h0, 1'b1, erd, eadel, 1'b0, nm);
  endtask

  task automatic st(input logic [1:0] s, input logic [31:0] a, input logic [31:0] wd,
                    input logic eades, input string nm);
    op(1'b0, 1'b1, s, 3'b000, a, wd, 1'b0, 32'h0, 1'b0, eades, nm);
  endtask

  // Monitor: compare the DUT outputs mid-cycle for each queued operation.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if ((e.chk_rd && RD !== e.rd) || AdEL !== e.adel || AdES !== e.ades) begin
        errors++;
        $display("FAIL %s: got RD=%h AdEL=%b AdES=%b, expected RD=%h AdEL=%b AdES=%b%s",
                 nm, RD, AdEL, AdES, e.rd, e.adel, e.ades, e.chk_rd ? "" : " (RD not checked)");
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; MemWrite = 1'b0; StoreType = 2'b00; LoadType = 3'b000;
    Addr = 32'h0; WD = 32'h0; PC_M = 32'h0040_0000;
    @(posedge clk);
    #1 reset = 1'b0;

    // Reset state and range boundaries
    ld(3'b000, 32'h0000_0000, 32'h0, 1'b0, "rst_lw_0");
    ld(3'b000, 32'h0000_0FFC, 32'h0, 1'b0, "rst_lw_ffc");
    ld(3'b000, 32'h0000_1000, 32'h0, 1'b1, "lw_oor_1000");

    // Word store and extended loads; same-cycle read sees old data
    op(1'b0, 1'b1, 2'b00, 3'b000, 32'h8, 32'h1234_5678, 1'b1, 32'h0, 1'b0, 1'b0, "sw_8_oldrd");
    ld(3'b000, 32'h8, 32'h1234_5678, 1'b0, "lw_8");
    ld(3'b010, 32'hB, 32'h0000_0012, 1'b0, "lb_b");
    ld(3'b100, 32'hA, 32'h0000_1234, 1'b0, "lh_a");
    ld(3'b001, 32'h9, 32'h0000_0056, 1'b0, "lbu_9");
    ld(3'b011, 32'h8, 32'h0000_5678, 1'b0, "lhu_8");

    // Byte store with sign/zero extension
    st(2'b00, 32'h10, 32'h0, 1'b0, "sw_10");
    st(2'b10, 32'h11, 32'hAAAA_AA80, 1'b0, "sb_11");
    ld(3'b010, 32'h11, 32'hFFFF_FF80, 1'b0, "lb_11");
    ld(3'b001, 32'h11, 32'h0000_0080, 1'b0, "lbu_11");
    ld(3'b000, 32'h10, 32'h0000_8000, 1'b0, "lw_10");

    // Halfword store over existing data
    st(2'b00, 32'h20, 32'h1111_1111, 1'b0, "sw_20");
    st(2'b01, 32'h22, 32'h5555_BEEF, 1'b0, "sh_22");
    ld(3'b000, 32'h20, 32'hBEEF_1111, 1'b0, "lw_20");
    ld(3'b100, 32'h22, 32'hFFFF_BEEF, 1'b0, "lh_22");
    ld(3'b011, 32'h22, 32'h0000_BEEF, 1'b0, "lhu_22");
    ld(3'b100, 32'h20, 32'h0000_1111, 1'b0, "lh_20");

    // Address exceptions suppress writes / zero load data
    st(2'b00, 32'h6, 32'hFFFF_FFFF, 1'b1, "sw_6_mis");
    st(2'b00, 32'h1000, 32'hFFFF_FFFF, 1'b1, "sw_1000_oor");
    st(2'b01, 32'h21, 32'hFFFF_FFFF, 1'b1, "sh_21_mis");
    st(2'b11, 32'h24, 32'hFFFF_FFFF, 1'b1, "st_rsv_24");
    ld(3'b000, 32'h4, 32'h0, 1'b0, "lw_4_unch");
    ld(3'b000, 32'h0, 32'h0, 1'b0, "lw_0_nowrap");
    ld(3'b000, 32'h20, 32'hBEEF_1111, 1'b0, "lw_20_unch");
    ld(3'b000, 32'h24, 32'h0, 1'b0, "lw_24_unch");
    ld(3'b000, 32'h2, 32'h0, 1'b1, "lw_2_mis");
    ld(3'b100, 32'h21, 32'h0, 1'b1, "lh_21_mis");
    ld(3'b010, 32'h21, 32'h0000_0011, 1'b0, "lb_21");

    // Byte stores accumulate lane by lane
    st(2'b10, 32'h30, 32'h0000_00DD, 1'b0, "sb_30");
    st(2'b10, 32'h31, 32'h0000_00CC, 1'b0, "sb_31");
    st(2'b10, 32'h32, 32'h0000_00BB, 1'b0, "sb_32");
    st(2'b10, 32'h33, 32'h0000_00AA, 1'b0, "sb_33");
    ld(3'b000, 32'h30, 32'hAABB_CCDD, 1'b0, "lw_30_acc");

    // Reset wins over a same-edge store and clears the array
    op(1'b1, 1'b1, 2'b00, 3'b000, 32'h4, 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b0, 1'b0, "sw_4_rst");
    ld(3'b000, 32'h4, 32'h0, 1'b0, "lw_4_after_rst");
    ld(3'b000, 32'h8, 32'h0, 1'b0, "lw_8_after_rst");
    op(1'b0, 1'b1, 2'b00, 3'b000, 32'hC, 32'hCAFE_F00D, 1'b1, 32'h0, 1'b0, 1'b0, "sw_c_oldrd");
    ld(3'b000, 32'hC, 32'hCAFE_F00D, 1'b0, "lw_c_new");
    ld(3'b111, 32'hC, 32'hCAFE_F00D, 1'b0, "ld_other_c");
    ld(3'b111, 32'hE, 32'h0, 1'b1, "ld_other_e_mis");
    ld(3'b000, 32'h0, 32'h0, 1'b0, "idle");

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses left unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
